clk_div_bank: RTL and testbench

//  N-channel programmable clock divider bank driven from the 100 MHz board clock CLK_I.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 68 ++++++
 rtl/clk_div_bank.sv | 61 ++++++
 tb/tb_clk_div_bank.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, config struct and frequency helper for the clock divider bank
package clk_div_pkg;

  localparam int unsigned SYS_CLK_HZ    = 100_000_000;
  localparam int unsigned DEFAULT_CNT_W = 27;

  typedef struct packed {
    logic [DEFAULT_CNT_W-1:0] half;
  } ch_cfg_t;

  // Half-period in CLK_I cycles for a requested output frequency
  function automatic int unsigned half_of(input int unsigned freq_hz);
    return SYS_CLK_HZ / (2 * freq_hz);
  endfunction

  localparam int unsigned DEFAULT_HALF = half_of(500);

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: half-period counter, shadow/active registers, toggle and tick
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = DEFAULT_CNT_W,
  parameter int unsigned DEF_HALF = DEFAULT_HALF
) (
  input  logic             CLK_I,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] last_cnt;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  // A zero half-period compares against 0, so it behaves exactly like 1
  assign last_cnt = (active_q == '0) ? '0 : active_q - CNT_W'(1);

  always_comb begin
    shadow_d = wr_i ? half_i : shadow_q;
    cnt_d    = cnt_q + CNT_W'(1);
    clk_d    = clk_q;
    active_d = active_q;
    tick_d   = 1'b0;
    // Idle and realign share one path: counting restarts at 0 with the shadow value
    if (!en_i || sync_i) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      active_d = shadow_q;
    end else if (cnt_q == last_cnt) begin
      cnt_d    = '0;
      clk_d    = ~clk_q;
      active_d = shadow_q;
      tick_d   = ~clk_q;
    end
  end

  always_ff @(posedge CLK_I or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= HALF_RST;
      active_q <= HALF_RST;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - N-channel programmable clock divider bank; CLK_DIV_BANK_SYNC_EN adds sync_i phase realign
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int unsigned SYS_CLK  = SYS_CLK_HZ,
  parameter  int unsigned N_CH     = 4,
  parameter  int unsigned CNT_W    = DEFAULT_CNT_W,
  parameter  int unsigned DEF_HALF = SYS_CLK / (2 * 500),
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK_I,
  input  logic             rst,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ack,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  tick_o
);

  logic sync_w;
  logic cfg_ack_q;

`ifdef CLK_DIV_BANK_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range channel indices match no instance but are still acknowledged
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .CLK_I  (CLK_I),
      .rst    (rst),
      .en_i   (ch_en[i]),
      .sync_i (sync_w),
      .wr_i   (cfg_wr && (int'(cfg_ch) == i)),
      .half_i (cfg_half),
      .clk_o  (clk_o[i]),
      .tick_o (tick_o[i])
    );
  end

  always_ff @(posedge CLK_I or posedge rst) begin
    if (rst) begin
      cfg_ack_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_wr;
    end
  end

  assign cfg_ack = cfg_ack_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank: toggle-time model plus directed literal checks
module tb_clk_div_bank;

  localparam int N     = 5;
  localparam int HALF0 = 20;

  logic        CLK_I = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic        sync_r = 1'b0;
  logic [N-1:0] ch_en = '0;
  logic [2:0]  cfg_ch = '0;
  logic [26:0] cfg_half = '0;
  logic        cfg_ack;
  logic [N-1:0] clk_o, tick_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit m_lvl[N], m_tick[N], m_was_en[N];
  int m_act[N], m_shd[N], m_nxt[N];
  bit m_ack;
  logic [N-1:0] exp_clk, exp_tick;

  clk_div_bank #(
    .N_CH     (N),
    .CNT_W    (27),
    .DEF_HALF (HALF0)
  ) dut (
    .CLK_I    (CLK_I),
    .rst      (rst),
`ifdef CLK_DIV_BANK_SYNC_EN
    .sync_i   (sync_r),
`endif
    .ch_en    (ch_en),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .cfg_ack  (cfg_ack),
    .clk_o    (clk_o),
    .tick_o   (tick_o)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, a, e);
    end
  endtask

  function automatic int eff(input int a);
    return (a == 0) ? 1 : a;
  endfunction

  // Model tracks the absolute edge number of each channel's next toggle
  function automatic void model_reset();
    cyc = 0;
    m_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = 1'b0; m_tick[i] = 1'b0; m_was_en[i] = 1'b0;
      m_act[i] = HALF0; m_shd[i] = HALF0; m_nxt[i] = 0;
    end
  endfunction

  function automatic void model_step();
    int old_shd;
    cyc++;
    for (int i = 0; i < N; i++) begin
      old_shd = m_shd[i];
      m_tick[i] = 1'b0;
      if (!ch_en[i]) begin
        m_lvl[i] = 1'b0; m_act[i] = old_shd; m_was_en[i] = 1'b0;
      end else if (sync_r) begin
        m_lvl[i] = 1'b0; m_act[i] = old_shd; m_was_en[i] = 1'b1;
        m_nxt[i] = cyc + eff(m_act[i]);
      end else begin
        if (!m_was_en[i]) begin
          m_nxt[i] = cyc - 1 + eff(m_act[i]);
          m_was_en[i] = 1'b1;
        end
        if (cyc == m_nxt[i]) begin
          m_lvl[i] = !m_lvl[i];
          m_tick[i] = m_lvl[i];
          m_act[i] = old_shd;
          m_nxt[i] = cyc + eff(m_act[i]);
        end
      end
      if (cfg_wr && int'(cfg_ch) == i) m_shd[i] = int'(cfg_half);
    end
    m_ack = cfg_wr;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge CLK_I or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge CLK_I);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          exp_clk[i] = m_lvl[i];
          exp_tick[i] = m_tick[i];
        end
        chk("model_clk_o", 32'(clk_o), 32'(exp_clk));
        chk("model_tick_o", 32'(tick_o), 32'(exp_tick));
        chk("model_cfg_ack", 32'(cfg_ack), 32'(m_ack));
      end
    end
  end

  task automatic at_cycle(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge CLK_I);
      guard++;
    end
    if (cyc != n) chk("at_cycle_reach", 32'(cyc), 32'(n));
  endtask

  task automatic wr(input int n, input int ch, input int half);
    at_cycle(n);
    cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_half = 27'(half);
    at_cycle(n + 1);
    cfg_wr = 1'b0;
    chk("lit_cfg_ack", 32'(cfg_ack), 32'd1);
  endtask

  initial begin
    ch_en = 5'b00001;
    @(negedge CLK_I);
    chk("lit_rst_clk_o", 32'(clk_o), 32'd0);
    chk("lit_rst_tick_o", 32'(tick_o), 32'd0);
    chk("lit_rst_cfg_ack", 32'(cfg_ack), 32'd0);
    repeat (2) @(negedge CLK_I);
    #1 rst = 1'b0;

    at_cycle(19); chk("t1_clk0_c19", 32'(clk_o[0]), 32'd0);
    at_cycle(20); chk("t1_clk0_c20", 32'(clk_o[0]), 32'd1);
    chk("t1_tick0_c20", 32'(tick_o[0]), 32'd1);
    chk("t1_others_c20", 32'(clk_o[4:1]), 32'd0);
    at_cycle(21); chk("t1_tick0_c21", 32'(tick_o[0]), 32'd0);
    at_cycle(40); chk("t1_clk0_c40", 32'(clk_o[0]), 32'd0);
    at_cycle(60); chk("t1_tick0_c60", 32'(tick_o[0]), 32'd1);

    wr(61, 1, 10);
    at_cycle(63); ch_en = 5'b00011;
    at_cycle(73); chk("t2_tick1_c73", 32'(tick_o[1]), 32'd1);
    wr(75, 1, 5);
    at_cycle(83); chk("t2_clk1_c83", 32'(clk_o[1]), 32'd0);
    at_cycle(87); chk("t2_clk1_c87", 32'(clk_o[1]), 32'd0);
    at_cycle(88); chk("t2_tick1_c88", 32'(tick_o[1]), 32'd1);
    at_cycle(93); chk("t2_clk1_c93", 32'(clk_o[1]), 32'd0);

    at_cycle(99); ch_en = 5'b00111;
    wr(118, 2, 3);
    chk("t3_tick2_c119", 32'(tick_o[2]), 32'd1);
    at_cycle(138); chk("t3_clk2_c138", 32'(clk_o[2]), 32'd1);
    at_cycle(139); chk("t3_clk2_c139", 32'(clk_o[2]), 32'd0);
    at_cycle(141); chk("t3_clk2_c141", 32'(clk_o[2]), 32'd0);
    at_cycle(142); chk("t3_tick2_c142", 32'(tick_o[2]), 32'd1);
    at_cycle(145); chk("t3_clk2_c145", 32'(clk_o[2]), 32'd0);

    wr(150, 3, 0);
    at_cycle(152); ch_en = 5'b01111;
    at_cycle(153); chk("t4_tick3_c153", 32'(tick_o[3]), 32'd1);
    at_cycle(154); chk("t4_clk3_c154", 32'(clk_o[3]), 32'd0);
    at_cycle(155); chk("t4_tick3_c155", 32'(tick_o[3]), 32'd1);
    wr(156, 3, 1);
    at_cycle(160); chk("t4_clk3_c160", 32'(clk_o[3]), 32'd0);
    at_cycle(161); chk("t4_tick3_c161", 32'(tick_o[3]), 32'd1);

    wr(162, 4, 9);
    wr(163, 4, 6);
    at_cycle(166); ch_en = 5'b11111;
    at_cycle(172); chk("t4_tick4_c172", 32'(tick_o[4]), 32'd1);
    at_cycle(178); chk("t4_clk4_c178", 32'(clk_o[4]), 32'd0);

    wr(180, 7, 2);
    at_cycle(190); chk("t5_clk0_c190", 32'(clk_o[0]), 32'd1);
    ch_en = 5'b11110;
    at_cycle(191); chk("t5_clk0_off", 32'(clk_o[0]), 32'd0);
    at_cycle(195); ch_en = 5'b11111;
    at_cycle(214); chk("t5_clk0_c214", 32'(clk_o[0]), 32'd0);
    at_cycle(215); chk("t5_tick0_c215", 32'(tick_o[0]), 32'd1);

    at_cycle(230); chk("t6_clk0_pre", 32'(clk_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_clk_o", 32'(clk_o), 32'd0);
    chk("t6_rst_tick_o", 32'(tick_o), 32'd0);
    chk("t6_rst_cfg_ack", 32'(cfg_ack), 32'd0);
    repeat (2) @(negedge CLK_I);
    #1 rst = 1'b0;
    at_cycle(19); chk("t6_clk_c19", 32'(clk_o), 32'd0);
    at_cycle(20); chk("t6_clk_c20", 32'(clk_o), 32'h1f);
    chk("t6_tick_c20", 32'(tick_o), 32'h1f);

`ifdef CLK_DIV_BANK_SYNC_EN
    at_cycle(30); sync_r = 1'b1;
    at_cycle(31); sync_r = 1'b0;
    chk("t6_sync_clk", 32'(clk_o), 32'd0);
    at_cycle(51); chk("t6_sync_tick", 32'(tick_o), 32'h1f);
`endif

    at_cycle(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
